// File: rtl/seg7_pkg.sv
// Shared types, font table and double-dabble helper
// for the eight-digit 7-segment display driver.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [1:0] BB_IDLE  = 2'd0;
  localparam logic [1:0] BB_SHIFT = 2'd1;
  localparam logic [1:0] BB_DONE  = 2'd2;

  localparam int BCD_DIGITS = 10;

  // Add 3 to every BCD digit that is 5 or more, ahead of the next shift
  function automatic logic [39:0] dabble_adj(
    input logic [39:0] acc
  );
    logic [39:0] r;
    bcd_t d;
    r = acc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      d = r[4*i +: 4];
      if (d >= 4'd5) begin
        r[4*i +: 4] = d + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_show_bin2bcd.sv
// Sequential 32-bit binary to 10-digit BCD converter
// using shift-add-3, one input bit per clock.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd
);

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] sh;
  logic [39:0] acc;
  logic [39:0] adj;

  assign adj  = dabble_adj(acc);
  assign busy = (state != BB_IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= BB_IDLE;
      cnt   <= '0;
      sh    <= '0;
      acc   <= '0;
      bcd   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        BB_IDLE: begin
          if (start) begin
            state <= BB_SHIFT;
            sh    <= bin;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        BB_SHIFT: begin
          {acc, sh} <= {adj[38:0], sh, 1'b0};
          cnt       <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= BB_DONE;
          end
        end
        BB_DONE: begin
          bcd   <= acc;
          done  <= 1'b1;
          state <= BB_IDLE;
        end
        default: state <= BB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg7_show.sv
// Eight-digit multiplexed 7-segment driver, hex or
// decimal view of a 32-bit value, active-low outputs.
module seg7_show
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int NDIG     = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        mod,
  input  logic [31:0] data,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [31:0]   last;
  logic          first;
  logic [31:0]   disp;
  logic [39:0]   conv;
  logic          busy;
  logic          done;
  logic          start;
  logic          refresh;
  bcd_t          nib;
  logic          unused_hi;

  assign unused_hi = ^conv[39:32];

  // Converter runs in both modes so a mode switch needs no reconversion
  assign start = !busy && (first || (data != last));

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .bin   (data),
    .busy  (busy),
    .done  (done),
    .bcd   (conv)
  );

  assign refresh = (cnt == '0);

  always_comb begin
    nib = '0;
    if (mod) begin
      nib = data[{idx, 2'b00} +: 4];
    end else begin
      nib = disp[{idx, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt   <= '0;
      idx   <= '0;
      AN    <= 8'hFF;
      SEG   <= SEG_BLANK;
      first <= 1'b1;
      last  <= '0;
      disp  <= '0;
    end else begin
      if (cnt == CMAX) begin
        cnt <= '0;
        idx <= idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (refresh) begin
        AN  <= ~(8'd1 << idx);
        SEG <= {1'b1, HEX_FONT[nib]};
      end
      if (start) begin
        first <= 1'b0;
        last  <= data;
      end
      if (done) begin
        disp <= conv[31:0];
      end
    end
  end

endmodule

// File: tb/tb_seg7_show.sv
// Scoreboard bench for seg7_show: stimulus pushes
// expected digit slots, a monitor checks each new slot.
module tb_seg7_show;

  logic        clk  = 1'b0;
  logic        clr  = 1'b1;
  logic        mod  = 1'b1;
  logic [31:0] data = 32'h0123ABCD;
  logic [7:0]  SEG;
  logic [7:0]  AN;

  seg7_show #(.SCAN_DIV(4), .NDIG(8)) dut (
    .clk  (clk),
    .clr  (clr),
    .mod  (mod),
    .data (data),
    .SEG  (SEG),
    .AN   (AN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    string      name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic trans   = 1'b0;
  logic seen100 = 1'b0;

  // Segment codes per digit, digit 0 in the low byte
  localparam logic [63:0] V_HEX  = 64'hC0F9A4B08883C6A1;
  localparam logic [63:0] V_DEC  = 64'hF9A4B0999282F880;
  localparam logic [63:0] V_OVF  = 64'h90999082F8A49092;
  localparam logic [63:0] V_ZERO = 64'hC0C0C0C0C0C0C0C0;
  localparam logic [63:0] V_200  = 64'hC0C0C0C0C0A4C0C0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [7:0] an,
                      input logic [7:0] seg,
                      input string nm);
    exp_t e;
    e.an   = an;
    e.seg  = seg;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic push8(input logic [63:0] v,
                       input string nm);
    for (int i = 0; i < 8; i++) begin
      push(~(8'd1 << i), v[8*i +: 8],
           $sformatf("%s_d%0d", nm, i));
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk({nm, "_drain"}, q.size(), 0);
    q.delete();
  endtask

  task automatic wait_an(input logic [7:0] an,
                         input string nm);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (AN == an) begin
        found = 1'b1;
        break;
      end
    end
    chk({nm, "_sync"}, {31'd0, found}, 1);
  endtask

  // Monitor: each new AN value is one digit slot
  logic [7:0] prev_an = 8'hFF;
  int         hold    = 0;
  exp_t       m;
  logic       ok;

  always @(negedge clk) begin
    if (clr) begin
      prev_an = 8'hFF;
      hold    = 0;
    end else begin
      hold++;
      if (AN != prev_an) begin
        if (prev_an != 8'hFF) begin
          chk("slot_len", hold, 4);
        end
        chk("onehot", $countones(~AN), 1);
        if (q.size() > 0) begin
          m = q.pop_front();
          chk({m.name, "_an"}, AN, m.an);
          chk({m.name, "_seg"}, SEG, m.seg);
        end else if (trans) begin
          if (AN == 8'hFB) begin
            ok = (SEG == 8'hC0) || (SEG == 8'hF9) ||
                 (SEG == 8'hA4);
            if (SEG == 8'hF9) seen100 = 1'b1;
          end else begin
            ok = (SEG == 8'hC0);
          end
          chk("mid_value", {31'd0, ok}, 1);
        end
        prev_an = AN;
        hold    = 0;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", AN, 8'hFF);
    chk("rst_seg", SEG, 8'hFF);

    push8(V_HEX, "hex");
    push(8'hFE, 8'hA1, "hex_wrap");
    clr = 1'b0;
    @(negedge clk);
    chk("first_an", AN, 8'hFE);
    drain("hex");

    mod  = 1'b0;
    data = 32'd12345678;
    repeat (80) @(negedge clk);
    wait_an(8'h7F, "dec");
    push8(V_DEC, "dec");
    drain("dec");

    data = 32'hFFFFFFFF;
    repeat (80) @(negedge clk);
    wait_an(8'h7F, "ovf");
    push8(V_OVF, "ovf");
    drain("ovf");

    data = 32'd0;
    repeat (80) @(negedge clk);
    wait_an(8'h7F, "zero");
    push8(V_ZERO, "zero");
    drain("zero");

    trans = 1'b1;
    data  = 32'd100;
    repeat (10) @(negedge clk);
    data = 32'd200;
    repeat (100) @(negedge clk);
    trans = 1'b0;
    chk("saw_100", {31'd0, seen100}, 1);
    wait_an(8'h7F, "d200");
    push8(V_200, "d200");
    drain("d200");

    wait_an(8'hFB, "arst");
    #2;
    clr = 1'b1;
    #1;
    chk("arst_an", AN, 8'hFF);
    chk("arst_seg", SEG, 8'hFF);
    push(8'hFE, 8'hC0, "arst_d0");
    push(8'hFD, 8'hC0, "arst_d1");
    push(8'hFB, 8'hC0, "arst_d2");
    repeat (2) @(negedge clk);
    clr = 1'b0;
    drain("arst");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1);
  end

endmodule
